// File: rtl/seq_mult4x4.sv
// seq_mult4x4: sequential unsigned 4x4 shift-add multiplier with an 8-bit product.
// Handshake: start is sampled on a rising clk edge while idle. done falls on that
// same edge. Operands a/b are captured one edge later, in LOAD. done rises together
// with the new out and stays high until the next accepted start. out holds its value
// between completions. start seen while busy is ignored.
// Optional build macro MULT4X4_FAST_EN: LOAD forms a*b directly and skips CALC,
// so the result arrives 2 clocks after start instead of 6.
module seq_mult4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] out,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] mcand;   // multiplicand, shifted left one place per iteration
  logic [3:0] mplier;  // multiplier, shifted right; its LSB gates each add
  logic [7:0] acc;     // running partial-product sum
  logic [2:0] cnt;     // iteration index 0..3

  // Controller and datapath: single registered FSM, all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= 8'd0;
      mplier <= 4'd0;
      acc    <= 8'd0;
      cnt    <= 3'd0;
      out    <= 8'd0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Operands are not sampled yet; the controller's muxes settle next cycle.
          if (start) begin
            done  <= 1'b0;
            state <= LOAD;
          end
        end
        LOAD: begin
          mcand  <= {4'd0, a};
          mplier <= b;
          cnt    <= 3'd0;
`ifdef MULT4X4_FAST_EN
          acc    <= {4'd0, a} * {4'd0, b};
          state  <= FIN;
`else
          acc    <= 8'd0;
          state  <= CALC;
`endif
        end
        CALC: begin
          // One multiplier bit per cycle; 15*15 fits in 8 bits, so the add cannot wrap.
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= {mcand[6:0], 1'b0};
          mplier <= {1'b0, mplier[3:1]};
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd3) begin
            state <= FIN;
          end
        end
        FIN: begin
          out   <= acc;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult4x4.sv
// tb_seq_mult4x4: randomized and directed checks of seq_mult4x4 against an
// arithmetic reference (product = a*b, with a and b taken in the cycle after start).
module tb_seq_mult4x4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] out;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_out;

`ifdef MULT4X4_FAST_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 6;
`endif

  seq_mult4x4 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .out  (out),
    .done (done)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver: one full operation. a0/b0 are shown in the start cycle, while a1/b1
  // are shown from the next cycle on and are the operands the product must use.
  task automatic run_mult(input logic [3:0] a0, input logic [3:0] b0,
                          input logic [3:0] a1, input logic [3:0] b1,
                          input bit hold, input bit scramble);
    int   n;
    int   prod;
    bit   seen;
    logic [7:0] exp;
    prod = int'(a1) * int'(b1);
    exp_q.push_back(prod[7:0]);
    start = 1'b1;
    a = a0;
    b = b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_clear_on_start: done=%b required 0", done);
    end
    checks++;
    if (out !== last_out) begin
      errors++;
      $display("FAIL out_hold_start: out=%0d required %0d", out, last_out);
    end
    start = hold;
    a = a1;
    b = b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (scramble) begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
      end
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        checks++;
        if (out !== last_out) begin
          errors++;
          $display("FAIL out_hold_busy: cycle %0d out=%0d required %0d", n, out, last_out);
        end
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done not seen within 20 cycles, a=%0d b=%0d", a1, b1);
    end else begin
      if (n != LAT) begin
        errors++;
        $display("FAIL latency: %0d cycles required %0d", n, LAT);
      end
      checks++;
      if (out !== exp) begin
        errors++;
        $display("FAIL product: a=%0d b=%0d out=%0d required %0d", a1, b1, out, exp);
      end
    end
    last_out = exp;
  endtask

  task automatic test_reset();
    checks++;
    if (out !== 8'd0) begin
      errors++;
      $display("FAIL reset_out: out=%0d required 0", out);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: done=%b required 0", done);
    end
    last_out = 8'd0;
  endtask

  task automatic test_idle_hold();
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || out !== last_out) begin
        errors++;
        $display("FAIL idle_hold: done=%b out=%0d required 1 and %0d", done, out, last_out);
      end
    end
  endtask

  task automatic test_directed();
    run_mult(4'd2, 4'd2, 4'd2, 4'd2, 1'b0, 1'b0);
    test_idle_hold();
    run_mult(4'd3, 4'd1, 4'd3, 4'd1, 1'b0, 1'b0);
    test_idle_hold();
    run_mult(4'd0, 4'd7, 4'd0, 4'd7, 1'b0, 1'b0);
    test_idle_hold();
    run_mult(4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 1'b0);
    test_idle_hold();
    run_mult(4'd1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
    test_idle_hold();
  endtask

  task automatic test_back_to_back();
    run_mult(4'd5, 4'd6, 4'd5, 4'd6, 1'b0, 1'b0);
    run_mult(4'd9, 4'd11, 4'd9, 4'd11, 1'b0, 1'b0);
    run_mult(4'd13, 4'd4, 4'd13, 4'd4, 1'b0, 1'b0);
  endtask

  task automatic test_start_held();
    for (int i = 0; i < 4; i++) begin
      run_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
    end
    start = 1'b0;
    test_idle_hold();
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        test_idle_hold();
      end
    end
    start = 1'b0;
    test_idle_hold();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    a = 4'd9;
    b = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out !== 8'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: out=%0d done=%b required 0 and 0", out, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_out = 8'd0;
    exp_q.delete();
    @(posedge clk); #1;
    checks++;
    if (out !== 8'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: out=%0d done=%b required 0 and 0", out, done);
    end
    run_mult(4'd7, 4'd5, 4'd7, 4'd5, 1'b0, 1'b0);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_directed();
    test_back_to_back();
    test_start_held();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
